// File: rtl/ks0108_pkg.sv
// Shared types and constants for the KS0108 panel write controller.
package ks0108_pkg;

    typedef enum logic [2:0] {
        RST_PULSE = 3'd0,
        INIT      = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        E_HIGH    = 3'd4,
        E_HOLD    = 3'd5
    } ks_state_t;

    localparam logic [7:0] CMD_DISPLAY_ON  = 8'h3F;
    localparam logic [7:0] CMD_START_LINE0 = 8'hC0;

    // req_chip encoding: bit0 drives CS1 (left half), bit1 drives CS2 (right half)
    localparam logic [1:0] CHIP_NONE = 2'b00;
    localparam logic [1:0] CHIP_CS1  = 2'b01;
    localparam logic [1:0] CHIP_CS2  = 2'b10;
    localparam logic [1:0] CHIP_BOTH = 2'b11;

    localparam int CNT_W = 16;

endpackage

// File: rtl/ks0108_if.sv
// Write-request handshake between a requester (master) and the KS0108 controller (slave).
interface ks0108_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_dc;
    logic [1:0] req_chip;
    logic [7:0] req_data;

    modport master (output req_valid, output req_dc, output req_chip, output req_data,
                    input  req_ready);
    modport slave  (input  req_valid, input  req_dc, input  req_chip, input  req_data,
                    output req_ready);
endinterface

// File: rtl/ks0108_phase_timer.sv
// Loadable down-counter: holds at zero, done while zero, reload on each phase entry.
module ks0108_phase_timer #(
    parameter int          CNT_W   = 16,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            cnt <= CNT_W'(RST_VAL);
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ks0108_ctrl.sv
// KS0108 graphic LCD write controller: reset pulse, optional init (KS0108_INIT_EN), timed bus cycles.
module ks0108_ctrl
    import ks0108_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 8,
    parameter int RST_CYC   = 16
) (
    input  logic       clk,
    input  logic       nreset,
    ks0108_if.slave    req,
    output logic       ks_dc,
    output logic       ks_cs1,
    output logic       ks_cs2,
    output logic       ks_e,
    output logic       ks_reset,
    output logic [7:0] ks_data,
    output logic       init_done,
    output logic       error
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_E     = CNT_W'(E_CYC - 1);

    ks_state_t        state, state_nxt;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             cap_en, cap_dc;
    logic [1:0]       cap_chip;
    logic [7:0]       cap_data;
    logic             dc_r, init_done_r, init_done_set, error_r, error_set, bus_active;
    logic [1:0]       chip_r;
    logic [7:0]       data_r;

    ks0108_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_CYC - 1)
    ) u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

`ifdef KS0108_INIT_EN
    logic [1:0] init_step;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            init_step <= 2'd0;
        else if (state == INIT && cap_en)
            init_step <= init_step + 2'd1;
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            state <= RST_PULSE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        cap_en        = 1'b0;
        cap_dc        = req.req_dc;
        cap_chip      = req.req_chip;
        cap_data      = req.req_data;
        init_done_set = 1'b0;
        error_set     = 1'b0;
        case (state)
            RST_PULSE: if (tmr_done) state_nxt = INIT;
            INIT: begin
`ifdef KS0108_INIT_EN
                if (init_step == 2'd2) begin
                    state_nxt     = IDLE;
                    init_done_set = 1'b1;
                end else begin
                    state_nxt = SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_SETUP;
                    cap_en    = 1'b1;
                    cap_dc    = 1'b0;
                    cap_chip  = CHIP_BOTH;
                    cap_data  = (init_step == 2'd0) ? CMD_DISPLAY_ON : CMD_START_LINE0;
                end
`else
                state_nxt     = IDLE;
                init_done_set = 1'b1;
`endif
            end
            IDLE: begin
                // A no-chip request is consumed here and only reported; the bus stays quiet.
                if (req.req_valid) begin
                    if (req.req_chip == CHIP_NONE) begin
                        error_set = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = LD_SETUP;
                        cap_en    = 1'b1;
                    end
                end
            end
            SETUP: if (tmr_done) begin
                state_nxt = E_HIGH;
                tmr_load  = 1'b1;
                tmr_val   = LD_E;
            end
            E_HIGH: if (tmr_done) begin
                state_nxt = E_HOLD;
                tmr_load  = 1'b1;
                tmr_val   = LD_E;
            end
            E_HOLD: if (tmr_done) state_nxt = init_done_r ? IDLE : INIT;
            default: state_nxt = RST_PULSE;
        endcase
    end

    always_comb begin
        bus_active    = (state == SETUP) || (state == E_HIGH) || (state == E_HOLD);
        req.req_ready = (state == IDLE);
        ks_reset      = (state != RST_PULSE);
        ks_e          = (state == E_HIGH);
        ks_cs1        = bus_active & chip_r[0];
        ks_cs2        = bus_active & chip_r[1];
        ks_dc         = dc_r;
        ks_data       = data_r;
        init_done     = init_done_r;
        error         = error_r;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dc_r        <= 1'b0;
            chip_r      <= CHIP_NONE;
            data_r      <= 8'h00;
            init_done_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            error_r <= error_set;
            if (init_done_set)
                init_done_r <= 1'b1;
            if (cap_en) begin
                dc_r   <= cap_dc;
                chip_r <= cap_chip;
                data_r <= cap_data;
            end
        end
    end

endmodule

// File: tb/tb_ks0108_ctrl.sv
// Randomized scoreboard bench for ks0108_ctrl; a negedge monitor checks every bus cycle and error pulse.
module tb_ks0108_ctrl;

    localparam int SETUP_CYC = 2;
    localparam int E_CYC     = 8;
    localparam int RST_CYC   = 16;
    localparam int BUS_LEN   = SETUP_CYC + 2 * E_CYC;
    localparam int ACC_GAP   = BUS_LEN + 1;
`ifdef KS0108_INIT_EN
    localparam int INIT_LAT  = 1 + 2 * ACC_GAP;
`else
    localparam int INIT_LAT  = 1;
`endif

    typedef struct packed {
        logic       dc;
        logic [1:0] chip;
        logic [7:0] data;
    } txn_t;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       ks_dc, ks_cs1, ks_cs2, ks_e, ks_reset, init_done, error;
    logic [7:0] ks_data;

    ks0108_if bus ();

    ks0108_ctrl #(
        .SETUP_CYC (SETUP_CYC),
        .E_CYC     (E_CYC),
        .RST_CYC   (RST_CYC)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req       (bus),
        .ks_dc     (ks_dc),
        .ks_cs1    (ks_cs1),
        .ks_cs2    (ks_cs2),
        .ks_e      (ks_e),
        .ks_reset  (ks_reset),
        .ks_data   (ks_data),
        .init_done (init_done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    txn_t exp_q[$];
    int   err_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: one bus cycle = contiguous span of asserted chip selects
    bit   in_bus = 0;
    int   ph_cyc, e_rise_at, e_len;
    bit   unstable, prev_e = 0;
    txn_t cur, want;

    always @(negedge clk) begin
        if (!nreset) begin
            in_bus = 0;
            prev_e = 0;
        end else begin
            if (!in_bus && (ks_cs1 || ks_cs2)) begin
                in_bus    = 1;
                ph_cyc    = 0;
                e_rise_at = -1;
                e_len     = 0;
                unstable  = 0;
                cur       = {ks_dc, ks_cs2, ks_cs1, ks_data};
                if (exp_q.size() == 0) check("unexpected_bus_cycle", int'(cur), -1);
                else begin
                    want = exp_q.pop_front();
                    check("bus_txn", int'(cur), int'(want));
                end
            end
            if (in_bus) begin
                if (ks_cs1 || ks_cs2) begin
                    if ({ks_dc, ks_cs2, ks_cs1, ks_data} != cur) unstable = 1;
                    if (ks_e && !prev_e) e_rise_at = ph_cyc;
                    if (ks_e) e_len++;
                    ph_cyc++;
                end else begin
                    check("setup_cycles", e_rise_at, SETUP_CYC);
                    check("e_high_cycles", e_len, E_CYC);
                    check("bus_cycle_len", ph_cyc, BUS_LEN);
                    check("bus_stable", int'(unstable), 0);
                    in_bus = 0;
                end
            end
            if (ks_e && !(ks_cs1 || ks_cs2)) check("e_without_cs", 1, 0);
            if (error) begin
                if (err_q.size() == 0) check("unexpected_error", 1, 0);
                else begin
                    void'(err_q.pop_front());
                    check("error_ready_held", int'(bus.req_ready), 1);
                    check("error_no_e", int'(ks_e), 0);
                end
            end
            prev_e = ks_e;
        end
    end

    // Driver state for the acceptance-interval model
    bit         have_prev = 0;
    int         prev_cyc;
    logic [1:0] prev_chip;

    task automatic apply_reset();
        int n;
        nreset = 1'b0;
        #1;
        check("rst_ks_reset", int'(ks_reset), 0);
        check("rst_strobes", int'({ks_e, ks_cs1, ks_cs2, ks_dc}), 0);
        check("rst_data", int'(ks_data), 0);
        check("rst_status", int'({bus.req_ready, init_done, error}), 0);
        exp_q.delete();
        err_q.delete();
        have_prev = 0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
`ifdef KS0108_INIT_EN
        exp_q.push_back({1'b0, 2'b11, 8'h3F});
        exp_q.push_back({1'b0, 2'b11, 8'hC0});
`endif
        n = 0;
        while (ks_reset == 1'b0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("ks_reset_low_cycles", n, RST_CYC);
        n = 0;
        while (!init_done && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("init_done_latency", n, INIT_LAT);
        check("ready_after_init", int'(bus.req_ready), 1);
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic dc, input logic [1:0] chip, input logic [7:0] data, input bit b2b);
        int k;
        if (!b2b) begin
            bus.req_valid = 1'b0;
            have_prev = 0;
            repeat ($urandom_range(0, 4)) begin
                bus.req_dc   = 1'($urandom);
                bus.req_chip = 2'($urandom);
                bus.req_data = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.req_valid = 1'b1;
        bus.req_dc    = dc;
        bus.req_chip  = chip;
        bus.req_data  = data;
        k = 0;
        while (!bus.req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            have_prev = 0;
        end else begin
            @(posedge clk);
            if (chip == 2'b00) err_q.push_back(1);
            else exp_q.push_back({dc, chip, data});
            @(negedge clk);
            if (have_prev)
                check("accept_interval", cyc - prev_cyc, (prev_chip == 2'b00) ? 1 : ACC_GAP);
            have_prev = 1;
            prev_cyc  = cyc;
            prev_chip = chip;
        end
    endtask

    initial begin
        int k;
        bus.req_valid = 1'b0;
        bus.req_dc    = 1'b0;
        bus.req_chip  = 2'b00;
        bus.req_data  = 8'h00;
        repeat (2) @(negedge clk);
        apply_reset();

        issue(1'b1, 2'b01, 8'hA5, 1'b0);
        issue(1'b1, 2'b01, 8'hA5, 1'b1);
        issue(1'b0, 2'b00, 8'h5A, 1'b1);
        issue(1'b0, 2'b10, 8'h3C, 1'b1);
        issue(1'b1, 2'b11, 8'hFF, 1'b0);
        issue(1'b0, 2'b00, 8'h11, 1'b0);
        issue(1'b0, 2'b00, 8'h22, 1'b1);

        for (int i = 0; i < 40; i++)
            issue(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), bit'($urandom_range(0, 1)));

        // Reset in the middle of E high drops the transfer at once
        issue(1'b1, 2'b11, 8'h96, 1'b0);
        bus.req_valid = 1'b0;
        k = 0;
        while (!ks_e && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reached_e_high", int'(ks_e), 1);
        repeat (3) @(negedge clk);
        apply_reset();

        issue(1'b0, 2'b01, 8'h42, 1'b0);
        bus.req_valid = 1'b0;
        repeat (BUS_LEN + 5) @(negedge clk);
        check("drain_bus_queue", exp_q.size(), 0);
        check("drain_error_queue", err_q.size(), 0);
        check("idle_strobes", int'({ks_e, ks_cs1, ks_cs2}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ks0108_ctrl.md
KS0108_CTRL -- requirements
Module: ks0108_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2, is the number of clk cycles that address, chip-select and data are set up before the E rising edge (minimum 1).
REQ-002 Parameter E_CYC, default 8, is the number of clk cycles of E high and, separately, of E-low hold per bus cycle (minimum 1).
REQ-003 Parameter RST_CYC, default 16, is the number of clk cycles that ks_reset is held low after reset release (minimum 1).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 Port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1 bit: the requester has a write pending.
REQ-007 Port req_ready, output, 1 bit: the controller accepts a request this cycle.
REQ-008 Port req_dc, input, 1 bit: 0 selects a command write, 1 selects a data write.
REQ-009 Port req_chip, input, 2 bits: bit0 selects CS1 (left half), bit1 selects CS2 (right half).
REQ-010 Port req_data, input, 8 bits: the byte to write.
REQ-011 Port ks_dc, ks_cs1, ks_cs2, ks_e, output, 1 bit each: panel strobes; chip selects are active-high.
REQ-012 Port ks_reset, output, 1 bit: active-low panel reset.
REQ-013 Port ks_data, output, 8 bits: panel data bus (write-only).
REQ-014 Port init_done, output, 1 bit: the power-up sequence is complete.
REQ-015 Port error, output, 1 bit: a one-cycle pulse on an illegal request.

Function
REQ-016 The controller SHALL use the states RST_PULSE, INIT, IDLE, SETUP, E_HIGH and E_HOLD.
REQ-017 The controller SHALL spend exactly RST_CYC cycles in RST_PULSE with ks_reset=0, then go to INIT.
REQ-018 req_ready SHALL equal (state==IDLE), and IDLE SHALL be reachable only after init_done=1.
REQ-019 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; the accepted req_dc, req_chip and req_data SHALL be registered, and later input changes SHALL be ignored.
REQ-020 An accepted request SHALL proceed SETUP (SETUP_CYC cycles, ks_e=0), then E_HIGH (E_CYC cycles, ks_e=1), then E_HOLD (E_CYC cycles, ks_e=0), then IDLE.
REQ-021 Throughout SETUP, E_HIGH and E_HOLD, ks_dc, ks_cs1, ks_cs2 and ks_data SHALL be held stable.
REQ-022 With defaults, the interval from one acceptance to the next possible acceptance SHALL be exactly SETUP_CYC+2*E_CYC+1 = 19 cycles.
REQ-023 In IDLE, ks_cs1=ks_cs2=0 and ks_e=0; ks_data and ks_dc SHALL retain their last values.
REQ-024 req_chip=2'b11 SHALL assert both chip selects in the same bus cycle (broadcast).
REQ-025 req_chip=2'b00 SHALL be accepted, SHALL produce no bus cycle, SHALL pulse error for 1 cycle, and SHALL leave the controller in IDLE so req_ready stays 1.
REQ-026 Phase timing SHALL use a single down-counter that is reloaded on each phase entry and that rolls over only at phase boundaries.

Reset
REQ-027 While nreset=0, the outputs SHALL be: ks_reset=0, ks_e=0, ks_cs1=ks_cs2=0, ks_dc=0, ks_data=8'h00, req_ready=0, init_done=0, error=0, and the state SHALL be RST_PULSE.
REQ-028 Reset asserted in any state, including mid-bus-cycle, SHALL take effect immediately; any in-flight transfer SHALL be dropped without completing E_HOLD.

Configuration
REQ-029 With KS0108_INIT_EN defined, INIT SHALL issue broadcast commands 8'h3F (display on) and then 8'hC0 (start line 0), each as a full bus cycle per REQ-020, and SHALL then set init_done and enter IDLE.
REQ-030 With KS0108_INIT_EN undefined, INIT SHALL last one cycle, SHALL set init_done and SHALL enter IDLE, with no bus cycles issued.

Structure
REQ-031 Package ks0108_pkg SHALL hold the state enum, the command constants CMD_DISPLAY_ON=8'h3F and CMD_START_LINE0=8'hC0, and the chip-select encoding constants.
REQ-032 Sub-module ks0108_phase_timer SHALL be the loadable down-counter with a done flag; all other logic SHALL stay in ks0108_ctrl.

Verification
REQ-033 Release reset with defaults and KS0108_INIT_EN undefined -> ks_reset is low for exactly 16 cycles, and init_done/req_ready are high 1 cycle later.
REQ-034 With KS0108_INIT_EN defined -> two E pulses occur with ks_cs1=ks_cs2=1 and ks_dc=0, the first with data 3F and the second with C0; init_done rises after the second E_HOLD.
REQ-035 Hold req_valid with dc=1, chip=01 and data=A5 -> ks_e is high for exactly 8 cycles, 2 cycles after the bus is driven; cs1=1, cs2=0 and data=A5 stay stable; the next acceptance occurs 19 cycles later.
REQ-036 Request chip=00 -> error pulses for 1 cycle, ks_e stays 0 and req_ready stays 1.
REQ-037 Assert nreset during E_HIGH -> ks_e, ks_cs1 and ks_cs2 drop in the same cycle, and the RST_PULSE sequence restarts.
REQ-038 Change req_data during E_HIGH -> ks_data is unchanged.
